coreabc_ram_sdp_param: RTL

//   Parametrised simple-dual-port RAM for the CoreABC low-level storage layer.

---
 rtl/coreabc_ram_pkg.sv | 28 ++
 rtl/coreabc_ram_sdp_array.sv | 24 ++
 rtl/coreabc_ram_sdp_param.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/coreabc_ram_pkg.sv
// CoreABC RAM shared types: FSM states, read-path select codes
// and the counter-width helper.
package coreabc_ram_pkg;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   typedef enum logic [1:0] {
      SEL_ZERO = 2'd0,
      SEL_MEM  = 2'd1,
      SEL_BYP  = 2'd2
   } rsel_t;

   function automatic int CLOG2(input int n);
      int r;
      int v;
      r = 0;
      v = n - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/coreabc_ram_sdp_array.sv
// Plain inferred storage: one write port, one registered read port.
// No reset, so synthesis maps it straight onto block RAM.
module coreabc_ram_sdp_array #(
   parameter int DW    = 8,
   parameter int AW    = 7,
   parameter int DEPTH = 128
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] wa,
   input  logic [DW-1:0] wd,
   input  logic          re,
   input  logic [AW-1:0] ra,
   output logic [DW-1:0] q
);

   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[wa] <= wd;
      if (re) q <= mem[ra];
   end

endmodule

// File: rtl/coreabc_ram_sdp_param.sv
// Parametrised SDP RAM: zero-fill sequencer, range checks, write-first
// bypass, optional output register and read-valid pipeline.
module coreabc_ram_sdp_param
   import coreabc_ram_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 7,
   parameter int DEPTH      = 128,
   parameter int OUT_REG    = 0,
   parameter int INIT_CLEAR = 1
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  CLR,
   input  logic                  WEN,
   input  logic [ADDR_WIDTH-1:0] WADDR,
   input  logic [DATA_WIDTH-1:0] WD,
   input  logic                  REN,
   input  logic [ADDR_WIDTH-1:0] RADDR,
   output logic [DATA_WIDTH-1:0] RD,
   output logic                  RVALID,
   output logic                  BUSY
);

   localparam int CW = (DEPTH > 1) ? CLOG2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH:0] LIM = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

   state_t st;
   state_t st_nx;
   logic [CW-1:0] cnt;

   logic run;
   logic wr_ok;
   logic rd_ok;
   logic rd_go;
   logic col;

   logic                  mwe;
   logic                  mre;
   logic [ADDR_WIDTH-1:0] mwa;
   logic [DATA_WIDTH-1:0] mwd;
   logic [DATA_WIDTH-1:0] q;

   logic                  v1;
   rsel_t                 rsel;
   logic [DATA_WIDTH-1:0] byp;
   logic [DATA_WIDTH-1:0] rd1;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) st <= (INIT_CLEAR != 0) ? ST_CLEAR : ST_RUN;
      else       st <= st_nx;
   end

   always_comb begin
      st_nx = st;
      unique case (st)
         ST_CLEAR: if (!CLR && cnt == LAST) st_nx = ST_RUN;
         ST_RUN:   if (CLR) st_nx = ST_CLEAR;
         default:  st_nx = ST_CLEAR;
      endcase
   end

   always_comb begin
      BUSY  = (st == ST_CLEAR);
      run   = !BUSY;
      wr_ok = run && WEN && ({1'b0, WADDR} < LIM);
      rd_ok = ({1'b0, RADDR} < LIM);
      rd_go = run && REN && !CLR;
      col   = wr_ok && rd_ok && (WADDR == RADDR);
      mwe   = BUSY || wr_ok;
      mwa   = BUSY ? ADDR_WIDTH'(cnt) : WADDR;
      mwd   = BUSY ? '0 : WD;
      mre   = rd_go && rd_ok && !col;
   end

   // CLR while clearing restarts the fill from location 0
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         cnt <= '0;
      end else if (st == ST_CLEAR) begin
         cnt <= (CLR || cnt == LAST) ? '0 : cnt + 1'b1;
      end else begin
         cnt <= '0;
      end
   end

   coreabc_ram_sdp_array #(
      .DW    (DATA_WIDTH),
      .AW    (ADDR_WIDTH),
      .DEPTH (DEPTH)
   ) u_array (
      .clk (CLK),
      .we  (mwe),
      .wa  (mwa),
      .wd  (mwd),
      .re  (mre),
      .ra  (RADDR),
      .q   (q)
   );

   // Select is only updated on an accepted read, so RD holds between reads
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         v1   <= 1'b0;
         rsel <= SEL_ZERO;
         byp  <= '0;
      end else begin
         v1 <= rd_go;
         if (rd_go) begin
            unique case (1'b1)
               !rd_ok:  rsel <= SEL_ZERO;
               col:     rsel <= SEL_BYP;
               default: rsel <= SEL_MEM;
            endcase
            if (col) byp <= WD;
         end
      end
   end

   always_comb begin
      unique case (rsel)
         SEL_MEM: rd1 = q;
         SEL_BYP: rd1 = byp;
         default: rd1 = '0;
      endcase
   end

   generate
      if (OUT_REG != 0) begin : g_oreg
         logic                  drop;
         logic [DATA_WIDTH-1:0] rd_q;
         logic                  rv_q;

         assign drop = run && CLR;

         always_ff @(posedge CLK or posedge RESET) begin
            if (RESET) begin
               rd_q <= '0;
               rv_q <= 1'b0;
            end else begin
               if (v1 && !drop) rd_q <= rd1;
               rv_q <= v1 && !drop;
            end
         end

         assign RD     = rd_q;
         assign RVALID = rv_q;
      end else begin : g_nreg
         assign RD     = rd1;
         assign RVALID = v1;
      end
   endgenerate

endmodule
